// File: rtl/ed25519_sigverify_dsdp_cmp_pkg.sv
// Shared constants, types and helpers for the signature-verify compare stage.
//   ED25519_P      field prime 2^255 - 19
//   CMP_W_M        job metadata width carried through the compare pipeline
//   ed25519_aff_t  affine point {x, y}
//   cmp_meta_t     per-job sideband {v, err, m}
//   canon()        reduce a value < 2^255 to canonical form with one subtraction
package ed25519_sigverify_dsdp_cmp_pkg;

  localparam logic [254:0] ED25519_P =
    255'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;

  localparam int unsigned CMP_W_M = 64;

  typedef struct packed {
    logic [254:0] x;
    logic [254:0] y;
  } ed25519_aff_t;

  typedef struct packed {
    logic               v;
    logic               err;
    logic [CMP_W_M-1:0] m;
  } cmp_meta_t;

  // Any v < 2^255 is below 2p, so one conditional subtraction is enough.
  function automatic logic [254:0] canon(input logic [254:0] v);
    return (v >= ED25519_P) ? v - ED25519_P : v;
  endfunction

endpackage

// File: rtl/ed25519_sigverify_dsdp_cmp_if.sv
// Handshake/data bundle of the compare stage.
//   r_*   : R point push (r_v/r_r handshake, affine x/y)
//   c_*   : C result from dsdp_mul (valid, metadata, extended x/y/z), always accepted
//   o_*   : per-job verdict (valid pulse, metadata, ok, pairing error)
//   r_cnt : R queue occupancy
// master = producer/consumer side, slave = compare stage.
interface ed25519_sigverify_dsdp_cmp_if #(
  parameter int unsigned W_M = 64,
  parameter int unsigned W_D = 8
);
  logic           r_v;
  logic           r_r;
  logic [254:0]   r_x;
  logic [254:0]   r_y;
  logic           c_v;
  logic [W_M-1:0] c_m;
  logic [254:0]   c_x;
  logic [254:0]   c_y;
  logic [254:0]   c_z;
  logic           o_v;
  logic [W_M-1:0] o_m;
  logic           o_ok;
  logic           o_err;
  logic [W_D-1:0] r_cnt;

  modport master (
    output r_v, r_x, r_y, c_v, c_m, c_x, c_y, c_z,
    input  r_r, o_v, o_m, o_ok, o_err, r_cnt
  );

  modport slave (
    input  r_v, r_x, r_y, c_v, c_m, c_x, c_y, c_z,
    output r_r, o_v, o_m, o_ok, o_err, r_cnt
  );
endinterface

// File: rtl/ed25519_sigverify_dsdp_cmp_mul_modp.sv
// Pipelined multiplier modulo 2^255 - 19.
//   clk : clock
//   a,b : operands (< 2^255)
//   p   : a*b mod p, MUL_D cycles later; result < 2^255 but not necessarily canonical
module ed25519_sigverify_dsdp_cmp_mul_modp #(
  parameter logic [31:0] MUL_T = 32'h007F_CCC2,
  parameter int unsigned MUL_D = 15
) (
  input  logic         clk,
  input  logic [254:0] a,
  input  logic [254:0] b,
  output logic [254:0] p
);
  logic [509:0] prod;
  logic [260:0] fold1;
  logic [255:0] fold2;
  logic [254:0] fold3;
  logic [254:0] pipe_q [MUL_D];

  // Fold high bits down using 2^255 == 19 (mod p) until the value fits in 255 bits.
  always_comb begin
    prod  = 510'(a) * 510'(b);
    fold1 = 261'(prod[254:0]) + 261'(prod[509:255]) * 261'd19;
    fold2 = 256'(fold1[254:0]) + 256'(fold1[260:255]) * 256'd19;
    fold3 = fold2[254:0] + (fold2[255] ? 255'd19 : 255'd0);
  end

  always_ff @(posedge clk) begin
    pipe_q[0] <= fold3;
    for (int unsigned i = 1; i < MUL_D; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign p = pipe_q[MUL_D-1];

  if (MUL_T == 32'd0 || MUL_D == 0) begin : g_bad_cfg
    $error("mul_modp: MUL_T must be non-zero and MUL_D at least 1");
  end

endmodule

// File: rtl/ed25519_sigverify_dsdp_cmp.sv
// Final signature-verify check: compares extended point C from dsdp_mul against the
// queued affine R (Cx == Rx*Cz, Cy == Ry*Cz, Cz != 0, all mod p).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of ed25519_sigverify_dsdp_cmp_if (R push, C input, verdict, r_cnt)
// Fixed latency MUL_D+3 from c_v to o_v, one job per cycle.
module ed25519_sigverify_dsdp_cmp
  import ed25519_sigverify_dsdp_cmp_pkg::*;
#(
  parameter logic [31:0] MUL_T   = 32'h007F_CCC2,
  parameter int unsigned MUL_D   = 15,
  parameter int unsigned W_M     = 64,
  parameter int unsigned R_DEPTH = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  ed25519_sigverify_dsdp_cmp_if.slave bus
);
  localparam int unsigned W_D = $clog2(R_DEPTH) + 1;
  localparam int unsigned W_A = $clog2(R_DEPTH);

  // R queue
  ed25519_aff_t   mem [R_DEPTH];
  ed25519_aff_t   head_q;
  logic [W_A-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [W_D-1:0] cnt_q;
  logic           push, pop;

  assign bus.r_r   = ~rst & (cnt_q != W_D'(R_DEPTH));
  assign push      = bus.r_v & bus.r_r;
  assign pop       = bus.c_v & (cnt_q != '0);
  assign rd_ptr_d  = rd_ptr_q + W_A'(pop);
  assign bus.r_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + W_A'(push);
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_q + W_D'(push) - W_D'(pop);
    end
  end

  // head_q always mirrors mem[rd_ptr_q]; a write landing on the next head slot is
  // forwarded because the array read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{x: bus.r_x, y: bus.r_y};
    if (push && (wr_ptr_q == rd_ptr_d)) head_q <= '{x: bus.r_x, y: bus.r_y};
    else                                head_q <= mem[rd_ptr_d];
  end

  // Compare pipeline
  cmp_meta_t    s0_meta_q, sr_meta_q;
  cmp_meta_t    meta_dly_q [MUL_D];
  ed25519_aff_t s0_r_q;
  logic [254:0] s0_cx_q, s0_cy_q, s0_cz_q;
  logic [254:0] cx_dly_q [MUL_D];
  logic [254:0] cy_dly_q [MUL_D];
  logic [254:0] cz_dly_q [MUL_D];
  logic [254:0] rxcz, rycz;
  logic [254:0] sr_cx_q, sr_cy_q, sr_cz_q, sr_rxcz_q, sr_rycz_q;
  logic         o_v_q, o_ok_q, o_err_q;
  logic [W_M-1:0] o_m_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_meta_q <= '0;
      for (int unsigned i = 0; i < MUL_D; i++) meta_dly_q[i] <= '0;
      sr_meta_q <= '0;
      o_v_q     <= 1'b0;
      o_ok_q    <= 1'b0;
      o_err_q   <= 1'b0;
      o_m_q     <= '0;
    end else begin
      s0_meta_q     <= '{v: bus.c_v, err: (cnt_q == '0), m: bus.c_m};
      meta_dly_q[0] <= s0_meta_q;
      for (int unsigned i = 1; i < MUL_D; i++) meta_dly_q[i] <= meta_dly_q[i-1];
      sr_meta_q <= meta_dly_q[MUL_D-1];
      o_v_q     <= sr_meta_q.v;
      o_err_q   <= sr_meta_q.v & sr_meta_q.err;
      o_ok_q    <= sr_meta_q.v & ~sr_meta_q.err & (sr_cx_q == sr_rxcz_q) &
                   (sr_cy_q == sr_rycz_q) & (sr_cz_q != '0);
      o_m_q     <= sr_meta_q.m;
    end
  end

  always_ff @(posedge clk) begin
    s0_cx_q     <= bus.c_x;
    s0_cy_q     <= bus.c_y;
    s0_cz_q     <= bus.c_z;
    s0_r_q      <= pop ? head_q : '0;
    cx_dly_q[0] <= s0_cx_q;
    cy_dly_q[0] <= s0_cy_q;
    cz_dly_q[0] <= s0_cz_q;
    for (int unsigned i = 1; i < MUL_D; i++) begin
      cx_dly_q[i] <= cx_dly_q[i-1];
      cy_dly_q[i] <= cy_dly_q[i-1];
      cz_dly_q[i] <= cz_dly_q[i-1];
    end
    sr_cx_q   <= canon(cx_dly_q[MUL_D-1]);
    sr_cy_q   <= canon(cy_dly_q[MUL_D-1]);
    sr_cz_q   <= canon(cz_dly_q[MUL_D-1]);
    sr_rxcz_q <= canon(rxcz);
    sr_rycz_q <= canon(rycz);
  end

  ed25519_sigverify_dsdp_cmp_mul_modp #(
    .MUL_T(MUL_T),
    .MUL_D(MUL_D)
  ) u_mul_x (
    .clk(clk),
    .a  (s0_r_q.x),
    .b  (s0_cz_q),
    .p  (rxcz)
  );

  ed25519_sigverify_dsdp_cmp_mul_modp #(
    .MUL_T(MUL_T),
    .MUL_D(MUL_D)
  ) u_mul_y (
    .clk(clk),
    .a  (s0_r_q.y),
    .b  (s0_cz_q),
    .p  (rycz)
  );

  assign bus.o_v   = o_v_q;
  assign bus.o_ok  = o_ok_q;
  assign bus.o_err = o_err_q;
  assign bus.o_m   = o_m_q;

  if (W_M != CMP_W_M) begin : g_bad_w_m
    $error("ed25519_sigverify_dsdp_cmp: W_M must equal CMP_W_M");
  end

endmodule

// File: tb/tb_ed25519_sigverify_dsdp_cmp.sv
// Self-checking bench for ed25519_sigverify_dsdp_cmp: directed cases plus random traffic,
// checked against a queue-based model using plain modular arithmetic.
module tb_ed25519_sigverify_dsdp_cmp;
  localparam int unsigned MUL_D   = 15;
  localparam int unsigned W_M     = 64;
  localparam int unsigned R_DEPTH = 128;
  localparam int unsigned W_D     = $clog2(R_DEPTH) + 1;
  localparam int          L       = MUL_D + 3;

  localparam logic [511:0] P512 = (512'd1 << 255) - 512'd19;
  localparam logic [254:0] P    = 255'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
  localparam logic [254:0] GX   = 255'h216936D3_CD6E53FE_C0A4E231_FDD6DC5C_692CC760_9525A7B2_C9562D60_8F25D51A;
  localparam logic [254:0] GY   = 255'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;

  typedef struct {
    int          due;
    logic [63:0] m;
    bit          ok;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [509:0] rq[$];   // model R queue, {x, y}
  exp_t         expq[$]; // expected verdicts in order

  ed25519_sigverify_dsdp_cmp_if #(.W_M(W_M), .W_D(W_D)) bus ();

  ed25519_sigverify_dsdp_cmp #(
    .MUL_T  (32'h007F_CCC2),
    .MUL_D  (MUL_D),
    .W_M    (W_M),
    .R_DEPTH(R_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [254:0] modp(input logic [254:0] v);
    logic [511:0] t;
    t = 512'(v) % P512;
    return t[254:0];
  endfunction

  function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] t;
    t = (512'(a) * 512'(b)) % P512;
    return t[254:0];
  endfunction

  function automatic logic [254:0] rnd255();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[254:0];
  endfunction

  function automatic bit ref_ok(input bit have, input logic [254:0] rx, input logic [254:0] ry,
                                input logic [254:0] cx, input logic [254:0] cy,
                                input logic [254:0] cz);
    if (!have) return 1'b0;
    return (modp(cx) == mulmod(rx, cz)) && (modp(cy) == mulmod(ry, cz)) && (modp(cz) != '0);
  endfunction

  // One cycle of stimulus, applied at a negedge; updates the model and returns at the next negedge.
  task automatic drive(input bit rv, input logic [254:0] rx, input logic [254:0] ry,
                       input bit cv, input logic [63:0] cm, input logic [254:0] cx,
                       input logic [254:0] cy, input logic [254:0] cz);
    exp_t         e;
    logic [509:0] h;
    bit           have, push_ok;
    check("r_cnt", 64'(bus.r_cnt), 64'(rq.size()));
    check("r_r", 64'(bus.r_r), 64'(rq.size() != R_DEPTH));
    bus.r_v = rv; bus.r_x = rx; bus.r_y = ry;
    bus.c_v = cv; bus.c_m = cm; bus.c_x = cx; bus.c_y = cy; bus.c_z = cz;
    push_ok = rv && (rq.size() != R_DEPTH);
    if (cv) begin
      have  = rq.size() != 0;
      h     = have ? rq[0] : '0;
      e.due = cyc + L;
      e.m   = cm;
      e.err = !have;
      e.ok  = ref_ok(have, h[509:255], h[254:0], cx, cy, cz);
      expq.push_back(e);
      if (have) void'(rq.pop_front());
    end
    if (push_ok) rq.push_back({rx, ry});
    @(posedge clk);
    @(negedge clk);
    bus.r_v = 1'b0;
    bus.c_v = 1'b0;
  endtask

  task automatic push_r(input logic [254:0] rx, input logic [254:0] ry);
    drive(1'b1, rx, ry, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic send_c(input logic [63:0] cm, input logic [254:0] cx, input logic [254:0] cy,
                        input logic [254:0] cz);
    drive(1'b0, '0, '0, 1'b1, cm, cx, cy, cz);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Output monitor: every o_v must match the oldest expected job at its exact due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.o_v) begin
        if (expq.size() == 0) begin
          check("stray_o_v", 64'd1, 64'd0);
        end else begin
          e = expq.pop_front();
          check("latency", 64'(cyc), 64'(e.due));
          check("o_m", bus.o_m, e.m);
          check("o_ok", 64'(bus.o_ok), 64'(e.ok));
          check("o_err", 64'(bus.o_err), 64'(e.err));
        end
      end else if (expq.size() != 0 && expq[0].due <= cyc) begin
        check("missing_o_v", 64'd0, 64'd1);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [254:0] hx, hy, z, cx, cy;
    bit           have;
    bus.r_v = 1'b0; bus.r_x = '0; bus.r_y = '0;
    bus.c_v = 1'b0; bus.c_m = '0; bus.c_x = '0; bus.c_y = '0; bus.c_z = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("r_r_in_rst", 64'(bus.r_r), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_o_v", 64'(bus.o_v), 64'd0);
    check("rst_o_ok", 64'(bus.o_ok), 64'd0);
    check("rst_o_err", 64'(bus.o_err), 64'd0);
    check("rst_r_cnt", 64'(bus.r_cnt), 64'd0);
    check("rst_r_r", 64'(bus.r_r), 64'd1);

    // Basic match, projective scale, non-canonical inputs, identity, Cz == 0
    push_r(GX, GY);
    send_c(64'hA1, GX, GY, 255'd1);
    push_r(GX, GY);
    send_c(64'hA2, mulmod(GX, 255'd2), mulmod(GY, 255'd2), 255'd2);
    push_r(GX, GY);
    push_r(255'd5, GY);
    push_r(GX, GY);
    send_c(64'hA3, GX, GY, P + 255'd1);
    send_c(64'hA4, P + 255'd5, GY, P + 255'd1);
    send_c(64'hA5, 255'd0, 255'd1, 255'd1);
    push_r(255'd0, 255'd0);
    push_r(255'd0, 255'd0);
    send_c(64'hA6, 255'd0, 255'd0, 255'd0);
    send_c(64'hA7, 255'd0, 255'd0, P);
    idle(L + 2);

    // Empty queue pairing fault, same-cycle push into empty, then normal pairing
    send_c(64'hB1, GX, GY, 255'd1);
    drive(1'b1, GX, GY, 1'b1, 64'hB2, GX, GY, 255'd1);
    send_c(64'hB3, GX, GY, 255'd1);
    push_r(GY, GX);
    idle(1);
    send_c(64'hB4, GY, GX, 255'd1);
    idle(L + 2);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      have = rq.size() != 0;
      hx = have ? rq[0][509:255] : modp(rnd255());
      hy = have ? rq[0][254:0] : modp(rnd255());
      z  = modp(rnd255());
      case ($urandom_range(0, 3))
        0:       begin cx = rnd255(); cy = rnd255(); z = rnd255(); end
        3:       begin cx = mulmod(hx, z); cy = mulmod(hy, z) ^ 255'd1; end
        default: begin cx = mulmod(hx, z); cy = mulmod(hy, z); end
      endcase
      drive(($urandom_range(0, 1) == 1), modp(rnd255()), modp(rnd255()),
            ($urandom_range(0, 2) == 0), {$urandom, $urandom}, cx, cy, z);
    end
    while (rq.size() != 0) send_c(64'hDD, rnd255(), rnd255(), rnd255());
    idle(L + 2);

    // Fill to R_DEPTH, attempt a push while full, then a back-to-back burst with odd jobs corrupted
    for (int i = 0; i < R_DEPTH; i++) push_r(modp(rnd255()), modp(rnd255()));
    push_r(GX, GY);
    for (int i = 0; i < R_DEPTH; i++) begin
      hx = rq[0][509:255];
      hy = rq[0][254:0];
      drive(1'b0, '0, '0, 1'b1, 64'(i), (i % 2 == 1) ? (hx ^ 255'd1) : hx, hy, 255'd1);
    end
    idle(L + 2);

    // Reset in the middle of a burst
    for (int i = 0; i < 10; i++) push_r(modp(rnd255()), modp(rnd255()));
    for (int i = 0; i < 5; i++) begin
      hx = rq[0][509:255];
      hy = rq[0][254:0];
      drive(1'b0, '0, '0, 1'b1, 64'(100 + i), hx, hy, 255'd1);
    end
    rst = 1'b1;
    #1;
    check("midrst_o_v", 64'(bus.o_v), 64'd0);
    check("midrst_r_cnt", 64'(bus.r_cnt), 64'd0);
    check("midrst_r_r", 64'(bus.r_r), 64'd0);
    expq.delete();
    rq.delete();
    idle(2);
    rst = 1'b0;
    idle(L + 5);
    push_r(GX, GY);
    send_c(64'hC1, GX, GY, 255'd1);
    idle(L + 2);

    check("drain", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
